// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a combinational-read instruction RAM and
// hands instructions to decode over valid/ready. Optional jump predecode: FETCH_JPREDECODE_EN.
module if_fetch_unit #(
    parameter int unsigned          DataWidth = 32,
    parameter int unsigned          AddrWidth = 32,
    parameter logic [AddrWidth-1:0] ResetPC   = '0
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    output logic [AddrWidth-1:0] Mem_Addr,
    output logic                 Mem_R,
    input  logic [DataWidth-1:0] Mem_R_data,
    input  logic                 Redirect,
    input  logic [AddrWidth-1:0] Redirect_PC,
    input  logic                 ID_ready,
    output logic [DataWidth-1:0] Instr,
    output logic [AddrWidth-1:0] Instr_PC,
    output logic                 Instr_valid,
    output logic                 Instr_jpred,
    output logic [31:0]          Fetch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [AddrWidth-1:0] pc_q, pc_d;
    logic [AddrWidth-1:0] pc_plus4;
    logic [DataWidth-1:0] instr_q, instr_d;
    logic [AddrWidth-1:0] ipc_q, ipc_d;
    logic                 valid_q, valid_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 xfer;
`ifdef FETCH_JPREDECODE_EN
    logic                 jpred_q, jpred_d;
    logic                 is_jump;
    logic [AddrWidth-1:0] jump_target;
`endif

    assign pc_plus4 = pc_q + AddrWidth'(4);
    assign xfer     = valid_q && ID_ready;

`ifdef FETCH_JPREDECODE_EN
    assign is_jump     = (Mem_R_data[31:26] == 6'b000010);
    assign jump_target = {pc_plus4[AddrWidth-1:28], Mem_R_data[25:0], 2'b00};
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
`ifdef FETCH_JPREDECODE_EN
        jpred_d = jpred_q;
`endif
        Mem_R   = (state_q == S_RUN);

        // A handshake still counts even when a redirect flushes the register in the same cycle.
        if (xfer) begin
            cnt_d = cnt_q + 32'd1;
        end

        if (Redirect) begin
            pc_d    = Redirect_PC & ~(AddrWidth'(3));
            valid_d = 1'b0;
            state_d = S_RUN;
`ifdef FETCH_JPREDECODE_EN
            jpred_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (!valid_q || ID_ready) begin
                        instr_d = Mem_R_data;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
`ifdef FETCH_JPREDECODE_EN
                        jpred_d = 1'b0;
                        if (is_jump) begin
                            pc_d    = jump_target;
                            jpred_d = 1'b1;
                        end
`endif
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    // RAM is not read here, so the accepted slot simply empties.
                    if (ID_ready) begin
                        valid_d = 1'b0;
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            pc_q    <= ResetPC;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FETCH_JPREDECODE_EN
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            jpred_q <= 1'b0;
        end else begin
            jpred_q <= jpred_d;
        end
    end

    assign Instr_jpred = jpred_q;
`else
    assign Instr_jpred = 1'b0;
`endif

    assign Mem_Addr    = pc_q;
    assign Instr       = instr_q;
    assign Instr_PC    = ipc_q;
    assign Instr_valid = valid_q;
    assign Fetch_cnt   = cnt_q;

    // Decode must see a stable instruction while it stalls.
    a_instr_stable: assert property (@(posedge CLK) disable iff (!RST_n)
        (Instr_valid && !ID_ready) |=> $stable(Instr));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-written reset/redirect/wrap sequences,
// then randomized handshake/redirect traffic against a transaction-level fetch model.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_JPREDECODE_EN
    localparam bit JP_ON = 1'b1;
`else
    localparam bit JP_ON = 1'b0;
`endif
    localparam logic [31:0] V16_ADDR  = JP_ON ? 32'h1C : 32'h18;
    localparam logic [31:0] V17_INSTR = JP_ON ? 32'hac83_2710 : 32'h0109_5020;
    localparam logic [31:0] V17_IPC   = JP_ON ? 32'h1C : 32'h18;
    localparam logic [31:0] V17_ADDR  = JP_ON ? 32'h20 : 32'h1C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_r;
    logic [31:0] mem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_jpred;
    logic [31:0] fetch_cnt;

    logic [31:0] ram [64];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    assign mem_rdata = ram[mem_addr[7:2]];

    always #5 clk = ~clk;

    if_fetch_unit #(
        .DataWidth(32),
        .AddrWidth(32),
        .ResetPC  (RESET_PC)
    ) dut (
        .CLK        (clk),
        .RST_n      (rst_n),
        .Mem_Addr   (mem_addr),
        .Mem_R      (mem_r),
        .Mem_R_data (mem_rdata),
        .Redirect   (redirect),
        .Redirect_PC(redirect_pc),
        .ID_ready   (id_ready),
        .Instr      (instr),
        .Instr_PC   (instr_pc),
        .Instr_valid(instr_valid),
        .Instr_jpred(instr_jpred),
        .Fetch_cnt  (fetch_cnt)
    );

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic [31:0] e_cnt;
        logic        e_memr;
        logic [31:0] e_addr;
        logic        e_jp;
    } vec_t;

    vec_t vt[18];

    // Transaction-level model: the output slot, the PC, and whether fetching is paused.
    logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
    logic        m_valid, m_jp, m_awake, m_waiting;

    function automatic vec_t mk(input logic rdy, input logic redir, input logic [31:0] rpc,
                                input logic v, input logic [31:0] ins, input logic [31:0] ipc,
                                input logic [31:0] cnt, input logic mr, input logic [31:0] addr,
                                input logic jp);
        vec_t r;
        r.rdy = rdy; r.redir = redir; r.rpc = rpc;
        r.e_valid = v; r.e_instr = ins; r.e_ipc = ipc; r.e_cnt = cnt;
        r.e_memr = mr; r.e_addr = addr; r.e_jp = jp;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [31:0] ins,
                             input logic [31:0] ipc, input logic [31:0] cnt, input logic mr,
                             input logic [31:0] addr, input logic jp);
        check({tag, " valid"}, 32'(instr_valid), 32'(v));
        check({tag, " instr"}, instr, ins);
        check({tag, " instr_pc"}, instr_pc, ipc);
        check({tag, " fetch_cnt"}, fetch_cnt, cnt);
        check({tag, " mem_r"}, 32'(mem_r), 32'(mr));
        check({tag, " mem_addr"}, mem_addr, addr);
        check({tag, " jpred"}, 32'(instr_jpred), 32'(jp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; reset asserts mid-cycle and releases after the next edge.
    task automatic pulse_reset(input bit check_zero);
        #2 rst_n = 1'b0;
        #1;
        if (check_zero) check_all("async reset", 1'b0, '0, '0, '0, 1'b0, RESET_PC, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_instr = '0; m_ipc = '0; m_cnt = '0;
        m_valid = 1'b0; m_jp = 1'b0; m_awake = 1'b0; m_waiting = 1'b0;
    endtask

    task automatic model_step(input logic rdy, input logic redir, input logic [31:0] rpc);
        logic [31:0] word;
        logic [31:0] nxt;
        if (m_valid && rdy) m_cnt = m_cnt + 32'd1;
        if (redir) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            m_valid = 1'b0; m_jp = 1'b0; m_awake = 1'b1; m_waiting = 1'b0;
        end else if (!m_awake) begin
            m_awake = 1'b1;
        end else if (m_waiting) begin
            if (rdy) begin
                m_valid = 1'b0;
                m_waiting = 1'b0;
            end
        end else if (m_valid && !rdy) begin
            m_waiting = 1'b1;
        end else begin
            word = ram[m_pc[7:2]];
            m_instr = word; m_ipc = m_pc; m_valid = 1'b1; m_jp = 1'b0;
            nxt = m_pc + 32'd4;
            if (JP_ON && word[31:26] == 6'b000010) begin
                nxt = {nxt[31:28], word[25:0], 2'b00};
                m_jp = 1'b1;
            end
            m_pc = nxt;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0000_0000;
        ram[0]  = 32'h0042_1821;
        ram[1]  = 32'h0062_1822;
        ram[2]  = 32'h0085_1820;
        ram[3]  = 32'h0083_1824;
        ram[4]  = 32'h00a6_1020;
        ram[5]  = 32'h0800_0007;
        ram[6]  = 32'h0109_5020;
        ram[7]  = 32'hac83_2710;
        ram[63] = 32'h2408_0005;

        vt[0]  = mk(1, 0, 32'h00, 0, 32'h0,          32'h00, 0, 1, 32'h00, 0);
        vt[1]  = mk(1, 0, 32'h00, 1, 32'h0042_1821,  32'h00, 0, 1, 32'h04, 0);
        vt[2]  = mk(1, 0, 32'h00, 1, 32'h0062_1822,  32'h04, 1, 1, 32'h08, 0);
        vt[3]  = mk(1, 0, 32'h00, 1, 32'h0085_1820,  32'h08, 2, 1, 32'h0C, 0);
        vt[4]  = mk(0, 0, 32'h00, 1, 32'h0085_1820,  32'h08, 2, 0, 32'h0C, 0);
        vt[5]  = mk(0, 0, 32'h00, 1, 32'h0085_1820,  32'h08, 2, 0, 32'h0C, 0);
        vt[6]  = mk(0, 0, 32'h00, 1, 32'h0085_1820,  32'h08, 2, 0, 32'h0C, 0);
        vt[7]  = mk(1, 0, 32'h00, 0, 32'h0085_1820,  32'h08, 3, 1, 32'h0C, 0);
        vt[8]  = mk(1, 0, 32'h00, 1, 32'h0083_1824,  32'h0C, 3, 1, 32'h10, 0);
        vt[9]  = mk(1, 0, 32'h00, 1, 32'h00a6_1020,  32'h10, 4, 1, 32'h14, 0);
        vt[10] = mk(1, 1, 32'h1F, 0, 32'h00a6_1020,  32'h10, 5, 1, 32'h1C, 0);
        vt[11] = mk(1, 0, 32'h00, 1, 32'hac83_2710,  32'h1C, 5, 1, 32'h20, 0);
        vt[12] = mk(0, 0, 32'h00, 1, 32'hac83_2710,  32'h1C, 5, 0, 32'h20, 0);
        vt[13] = mk(1, 1, 32'h04, 0, 32'hac83_2710,  32'h1C, 6, 1, 32'h04, 0);
        vt[14] = mk(1, 0, 32'h00, 1, 32'h0062_1822,  32'h04, 6, 1, 32'h08, 0);
        vt[15] = mk(1, 1, 32'h14, 0, 32'h0062_1822,  32'h04, 7, 1, 32'h14, 0);
        vt[16] = mk(1, 0, 32'h00, 1, 32'h0800_0007,  32'h14, 7, 1, V16_ADDR, JP_ON);
        vt[17] = mk(1, 0, 32'h00, 1, V17_INSTR,      V17_IPC, 8, 1, V17_ADDR, 0);

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, '0, '0, '0, 1'b0, RESET_PC, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            id_ready = vt[i].rdy;
            redirect = vt[i].redir;
            redirect_pc = vt[i].rpc;
            step();
            check_all($sformatf("vec%0d", i), vt[i].e_valid, vt[i].e_instr, vt[i].e_ipc,
                      vt[i].e_cnt, vt[i].e_memr, vt[i].e_addr, vt[i].e_jp);
        end
        redirect = 1'b0;

        // Stall, then pull reset mid-hold; fetch must restart cleanly from the reset PC.
        id_ready = 1'b0;
        step();
        check("hold mem_r", 32'(mem_r), 32'h0);
        check("hold valid", 32'(instr_valid), 32'h1);
        pulse_reset(1'b1);
        id_ready = 1'b1;
        step();
        check_all("restart idle", 1'b0, '0, '0, '0, 1'b1, RESET_PC, 1'b0);
        step();
        check_all("restart fetch", 1'b1, 32'h0042_1821, RESET_PC, '0, 1'b1, RESET_PC + 32'd4, 1'b0);

        // Redirect in the first cycle after release.
        pulse_reset(1'b0);
        redirect = 1'b1;
        redirect_pc = 32'h0000_000E;
        step();
        check_all("post-reset redirect", 1'b0, '0, '0, '0, 1'b1, 32'h0C, 1'b0);
        redirect = 1'b0;
        step();
        check_all("post-reset fetch", 1'b1, 32'h0083_1824, 32'h0C, '0, 1'b1, 32'h10, 1'b0);

        // PC wraps past the top of the address space.
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        check("wrap redirect addr", mem_addr, 32'hFFFF_FFFC);
        check("wrap redirect cnt", fetch_cnt, 32'd1);
        redirect = 1'b0;
        step();
        check_all("wrap fetch", 1'b1, 32'h2408_0005, 32'hFFFF_FFFC, 32'd1, 1'b1, 32'h0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 64; i++) begin
            ram[i] = $urandom();
            if ($urandom_range(0, 7) == 0) ram[i][31:26] = 6'b000010;
        end
        pulse_reset(1'b0);
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255));
            model_step(id_ready, redirect, redirect_pc);
            step();
            check_all($sformatf("rand%0d", c), m_valid, m_instr, m_ipc, m_cnt,
                      m_awake && !m_waiting, m_pc, m_jp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
